count_capture: RTL and testbench

- Downstream consumer of the 8-bit counter's `count` output.
- Samples the running count on a capture strobe and tags each sample with a wrap epoch, counted by detecting 0xFF→0x00 rollovers.
- Queues the tagged records in a small FIFO, drained through a valid/ready interface.
- Gives software/test logic a lossless or loss-flagged timestamp stream built on the free-running counter.

---
 rtl/count_pkg.sv | 23 ++
 rtl/capture_fifo.sv | 84 ++++++++
 rtl/count_capture.sv | 85 ++++++++
 tb/tb_count_capture.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_pkg
// Description : Shared widths and record types for the free-running counter
//               and its capture/timestamp consumer.
// Revision    : 1.0 - initial release
// ============================================================================
package count_pkg;

  localparam int CNT_W   = 8;
  localparam int EPOCH_W = 8;
  localparam int DEPTH   = 4;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [EPOCH_W-1:0] epoch_t;

  typedef struct packed {
    epoch_t epoch;
    cnt_t   count;
  } rec_t;

endpackage
`default_nettype wire

// File: rtl/capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : capture_fifo
// Description : Synchronous DEPTH-entry FIFO with occupancy count and a head
//               output taken straight from the storage flops.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         head_data
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             wr_en, rd_en;

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en     = push && (!full || pop);
  assign rd_en     = pop && !empty;
  assign level     = level_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_capture.sv
`default_nettype none
// ============================================================================
// Module      : count_capture
// Description : Samples the running count on a strobe, tags it with a wrap
//               epoch and queues the records for a valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module count_capture
  import count_pkg::*;
#(
  parameter int CNT_W   = count_pkg::CNT_W,
  parameter int EPOCH_W = count_pkg::EPOCH_W,
  parameter int DEPTH   = count_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CNT_W-1:0]           count_in,
  input  logic                       capture,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EPOCH_W+CNT_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [EPOCH_W-1:0]       epoch_q, epoch_d;
  logic                     overflow_q, overflow_d;
  logic                     wrap;
  logic [EPOCH_W-1:0]       epoch_eff;
  logic                     push, pop, drop;
  logic                     fifo_full, fifo_empty;
  logic [EPOCH_W+CNT_W-1:0] rec;

  assign wrap      = (cnt_q == '1) && (count_in == '0);
  // The epoch tag already includes a rollover seen in the capture cycle.
  assign epoch_eff = epoch_q + EPOCH_W'(wrap);
  assign rec       = {epoch_eff, count_in};
  assign push      = capture && !clear;
  assign pop       = out_valid && out_ready;
  assign drop      = push && fifo_full && !pop;
  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

  always_comb begin
    cnt_d      = count_in;
    epoch_d    = epoch_eff;
    overflow_d = overflow_q | drop;
    if (clear) begin
      epoch_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      epoch_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      epoch_q    <= epoch_d;
      overflow_q <= overflow_d;
    end
  end

  capture_fifo #(
    .WIDTH (EPOCH_W + CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clear),
    .push      (push),
    .pop       (pop),
    .push_data (rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level),
    .head_data (out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_count_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_capture
// Description : Vector table, directed corner sequences and randomized traffic
//               against a queue-based reference model of count_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_capture;
  import count_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  count_in;
  logic        capture, clear, out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  level;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  // reference model state
  rec_t       mq[$];
  logic [7:0] m_epoch, m_prev;
  logic       m_ovf;

  typedef struct {
    logic [7:0]  c;
    logic        cap, clr, rdy;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  el;
    logic        eo;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  count_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .count_in  (count_in),
    .capture   (capture),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_epoch = 8'h00;
    m_prev  = 8'h00;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] c, input logic cap, clr, rdy);
    bit   do_pop, was_full, wrapped;
    rec_t r;
    wrapped  = (m_prev == 8'hFF) && (c == 8'h00);
    r.epoch  = m_epoch + (wrapped ? 8'd1 : 8'd0);
    r.count  = c;
    do_pop   = (mq.size() > 0) && rdy;
    was_full = (mq.size() == 4);
    m_prev   = c;
    if (clr) begin
      mq.delete();
      m_epoch = 8'h00;
      m_ovf   = 1'b0;
    end else begin
      m_epoch = r.epoch;
      if (do_pop) void'(mq.pop_front());
      if (cap) begin
        if (!was_full || do_pop) mq.push_back(r);
        else                     m_ovf = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    chk("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("level", {29'd0, level}, 32'(mq.size()));
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (mq.size() != 0) chk("data", {16'd0, out_data}, {16'd0, mq[0]});
  endtask

  task automatic cyc(input logic [7:0] c, input logic cap, clr, rdy);
    count_in  = c;
    capture   = cap;
    clear     = clr;
    out_ready = rdy;
    @(posedge clk);
    #1;
    model_step(c, cap, clr, rdy);
    model_check();
  endtask

  function automatic vec_t mk(input logic [7:0] c, input logic cap, clr, rdy,
                              input logic ev, input logic [15:0] ed,
                              input logic [2:0] el, input logic eo);
    vec_t v;
    v.c = c; v.cap = cap; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    return v;
  endfunction

  initial begin
    logic [7:0] cur;
    rst_n = 1'b0; count_in = 8'h00; capture = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // basic capture, then wrap-tagged captures
    vecs.push_back(mk(8'h00, 0, 0, 1, 0, 16'h0000, 3'd0, 0));
    vecs.push_back(mk(8'h01, 0, 0, 1, 0, 16'h0000, 3'd0, 0));
    vecs.push_back(mk(8'h02, 0, 0, 1, 0, 16'h0000, 3'd0, 0));
    vecs.push_back(mk(8'h03, 1, 0, 1, 1, 16'h0003, 3'd1, 0));
    vecs.push_back(mk(8'h04, 0, 0, 1, 0, 16'h0000, 3'd0, 0));
    vecs.push_back(mk(8'h05, 0, 0, 1, 0, 16'h0000, 3'd0, 0));
    vecs.push_back(mk(8'hFE, 0, 0, 1, 0, 16'h0000, 3'd0, 0));
    vecs.push_back(mk(8'hFF, 0, 0, 1, 0, 16'h0000, 3'd0, 0));
    vecs.push_back(mk(8'h00, 1, 0, 1, 1, 16'h0100, 3'd1, 0));
    vecs.push_back(mk(8'h01, 1, 0, 1, 1, 16'h0101, 3'd1, 0));
    vecs.push_back(mk(8'h02, 0, 0, 1, 0, 16'h0000, 3'd0, 0));
    // clear, then overflow: five captures into four slots
    vecs.push_back(mk(8'h0F, 0, 1, 0, 0, 16'h0000, 3'd0, 0));
    vecs.push_back(mk(8'h10, 1, 0, 0, 1, 16'h0010, 3'd1, 0));
    vecs.push_back(mk(8'h11, 1, 0, 0, 1, 16'h0010, 3'd2, 0));
    vecs.push_back(mk(8'h12, 1, 0, 0, 1, 16'h0010, 3'd3, 0));
    vecs.push_back(mk(8'h13, 1, 0, 0, 1, 16'h0010, 3'd4, 0));
    vecs.push_back(mk(8'h14, 1, 0, 0, 1, 16'h0010, 3'd4, 1));
    vecs.push_back(mk(8'h15, 0, 0, 1, 1, 16'h0011, 3'd3, 1));
    vecs.push_back(mk(8'h16, 0, 0, 1, 1, 16'h0012, 3'd2, 1));
    vecs.push_back(mk(8'h17, 0, 0, 1, 1, 16'h0013, 3'd1, 1));
    vecs.push_back(mk(8'h18, 0, 0, 1, 0, 16'h0000, 3'd0, 1));
    // full + simultaneous pop admits the new record at the tail
    vecs.push_back(mk(8'h20, 0, 1, 0, 0, 16'h0000, 3'd0, 0));
    vecs.push_back(mk(8'h21, 1, 0, 0, 1, 16'h0021, 3'd1, 0));
    vecs.push_back(mk(8'h22, 1, 0, 0, 1, 16'h0021, 3'd2, 0));
    vecs.push_back(mk(8'h23, 1, 0, 0, 1, 16'h0021, 3'd3, 0));
    vecs.push_back(mk(8'h24, 1, 0, 0, 1, 16'h0021, 3'd4, 0));
    vecs.push_back(mk(8'h25, 1, 0, 1, 1, 16'h0022, 3'd4, 0));
    vecs.push_back(mk(8'h26, 0, 0, 1, 1, 16'h0023, 3'd3, 0));
    vecs.push_back(mk(8'h27, 0, 0, 1, 1, 16'h0024, 3'd2, 0));
    vecs.push_back(mk(8'h28, 0, 0, 1, 1, 16'h0025, 3'd1, 0));
    vecs.push_back(mk(8'h29, 0, 0, 1, 0, 16'h0000, 3'd0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].c, vecs[i].cap, vecs[i].clr, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_level", i), {29'd0, level}, {29'd0, vecs[i].el});
      chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].eo});
      if (vecs[i].ev) chk($sformatf("vec%0d_data", i), {16'd0, out_data}, {16'd0, vecs[i].ed});
    end

    // 256 rollovers bring the epoch back to zero
    cyc(8'h30, 0, 1, 0);
    for (int i = 0; i < 256; i++) begin
      cyc(8'hFF, 0, 0, 0);
      cyc(8'h00, 0, 0, 0);
    end
    cyc(8'h07, 1, 0, 0);
    chk("epoch_wrap_data", {16'd0, out_data}, 32'h0007);
    cyc(8'h08, 1, 1, 1);
    chk("clr_cap_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_cap_level", {29'd0, level}, 32'd0);
    chk("clr_cap_ovf", {31'd0, overflow}, 32'd0);

    // asynchronous reset with a full FIFO and sticky overflow
    for (int i = 0; i < 5; i++) cyc(8'h40 + 8'(i), 1, 0, 0);
    chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_level", {29'd0, level}, 32'd0);
    chk("async_ovf", {31'd0, overflow}, 32'd0);
    chk("async_data", {16'd0, out_data}, 32'd0);
    model_reset();
    count_in = 8'h00; capture = 1'b0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(8'h20, 1, 0, 0);
    chk("post_rst_data", {16'd0, out_data}, 32'h0020);

    // randomized traffic: mostly counting, with jumps, clears and back-pressure
    cur = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 88)      cur = cur + 8'd1;
      else if (r < 94) cur = 8'($urandom_range(0, 255));
      else             cur = 8'hFF;
      cyc(cur, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 55);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
